affine_seq: RTL and testbench

- Issuing/capturing end of the DDR affine ALU interface. Accepts affine term commands on a valid/ready stream and drives the ALU operand, control, phase and accumulator inputs.
- Captures the ALU result once per phase into two lane accumulators and returns the result pair on an output valid/ready stream.
- One ALU lane is evaluated per clock. `alu_clock_pol` is generated here as a registered phase signal.

---
 rtl/affine_seq.sv | 163 ++++++++++++++++
 tb/tb_affine_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/affine_seq.sv
// Sequencer for the DDR affine ALU: issues one lane per clock phase, captures
// the lane results into accumulators and returns the result pair on a stream.
module affine_seq #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_c,
  input  logic [N-1:0] in_d,
  input  logic [1:0]   in_mode,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_r1,
  output logic [N-1:0] out_r2,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [N-1:0] alu_c,
  output logic [N-1:0] alu_d,
  output logic [N-1:0] alu_acc1,
  output logic [N-1:0] alu_acc2,
  output logic [1:0]   alu_mul_a_sel,
  output logic [1:0]   alu_add_b_sel,
  output logic         alu_clock_pol,
  input  logic [N-1:0] alu_r
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PH1  = 2'd1,
    S_PH2  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_MUL = 2'b00;
  localparam logic [1:0] MODE_ADD = 2'b01;
  localparam logic [1:0] MODE_MAC = 2'b10;

  state_t      state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [N-1:0] acc1_q, acc1_d, acc2_q, acc2_d;
  logic [N-1:0] r1_q, r1_d, r2_q, r2_d;
  logic [1:0]   mode_q, mode_d;
  logic         last_q, last_d;
  logic         open_q, open_d;
  logic         pol_q, pol_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      acc1_q  <= '0;
      acc2_q  <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      mode_q  <= MODE_MUL;
      last_q  <= 1'b0;
      open_q  <= 1'b0;
      pol_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      acc1_q  <= acc1_d;
      acc2_q  <= acc2_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      open_q  <= open_d;
      pol_q   <= pol_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    acc1_d  = acc1_q;
    acc2_d  = acc2_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    mode_d  = mode_q;
    last_d  = last_q;
    open_d  = open_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d    = in_a;
          b_d    = in_b;
          c_d    = in_c;
          d_d    = in_d;
          last_d = in_last;
          // An open MAC group keeps its mode; the reserved code behaves as ADD.
          if (!open_q) begin
            mode_d = (in_mode == 2'b11) ? MODE_ADD : in_mode;
          end
          state_d = S_PH1;
        end
      end
      S_PH1: begin
        acc1_d  = alu_r;
        state_d = S_PH2;
      end
      S_PH2: begin
        acc2_d = alu_r;
        if (mode_q == MODE_MAC && !last_q) begin
          open_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          r1_d    = acc1_q;
          r2_d    = alu_r;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          acc1_d  = '0;
          acc2_d  = '0;
          open_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    pol_d = (state_d == S_PH1);
  end

  always_comb begin
    case (mode_q)
      MODE_MAC: alu_add_b_sel = 2'b00;
      MODE_ADD: alu_add_b_sel = 2'b10;
      default:  alu_add_b_sel = 2'b01;
    endcase
  end

  assign in_ready      = (state_q == S_IDLE);
  assign out_valid     = (state_q == S_OUT);
  assign out_r1        = r1_q;
  assign out_r2        = r2_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign alu_c         = c_q;
  assign alu_d         = d_q;
  assign alu_acc1      = acc1_q;
  assign alu_acc2      = acc2_q;
  assign alu_mul_a_sel = 2'b00;
  assign alu_clock_pol = pol_q;

endmodule

// File: tb/tb_affine_seq.sv
// Bench for affine_seq: directed and random affine commands, with a behavioural
// ALU on the interface and an arithmetic reference model for the result pairs.
module tb_affine_seq;

  localparam int N = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a, in_b, in_c, in_d;
  logic [1:0]   in_mode;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_r1, out_r2;
  logic [N-1:0] alu_a, alu_b, alu_c, alu_d;
  logic [N-1:0] alu_acc1, alu_acc2;
  logic [1:0]   alu_mul_a_sel, alu_add_b_sel;
  logic         alu_clock_pol;
  logic [N-1:0] alu_r;

  affine_seq #(.N(N)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r1(out_r1), .out_r2(out_r2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_d(alu_d),
    .alu_acc1(alu_acc1), .alu_acc2(alu_acc2),
    .alu_mul_a_sel(alu_mul_a_sel), .alu_add_b_sel(alu_add_b_sel),
    .alu_clock_pol(alu_clock_pol), .alu_r(alu_r)
  );

  always #5 clock = ~clock;

  // External ALU: product of the active lane plus the selected addend.
  logic [N-1:0] p1, p2;
  always_comb begin
    p1 = alu_a * alu_c;
    p2 = alu_b * alu_d;
    if (alu_clock_pol) begin
      case (alu_add_b_sel)
        2'b00:   alu_r = p1 + alu_acc1;
        2'b10:   alu_r = p1 + p2;
        default: alu_r = p1;
      endcase
    end else begin
      case (alu_add_b_sel)
        2'b00:   alu_r = p2 + alu_acc2;
        2'b10:   alu_r = p2 + p1;
        default: alu_r = p2;
      endcase
    end
  end

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  int       m1 = 0, m2 = 0;
  logic [1:0] m_mode = 2'b00;
  bit       m_open = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic term(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] d, input logic [1:0] mode, input logic last,
                      input bit abort, input bit stray_ready, input string tag,
                      output bit fin);
    int pa, pb, pc, pd, waited;
    logic [1:0] exp_sel;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    chk({tag, "_ready_before"}, in_ready, 1);
    in_valid = 1; in_a = a; in_b = b; in_c = c; in_d = d; in_mode = mode; in_last = last;

    pa = $signed(a); pb = $signed(b); pc = $signed(c); pd = $signed(d);
    if (!m_open) m_mode = (mode == 2'b11) ? 2'b01 : mode;
    case (m_mode)
      2'b00:   begin m1 = pa * pc; m2 = pb * pd; end
      2'b01:   begin m1 = pa * pc + pb * pd; m2 = m1; end
      default: begin m1 = m1 + pa * pc; m2 = m2 + pb * pd; end
    endcase
    fin = !(m_mode == 2'b10 && !last);
    exp_sel = (m_mode == 2'b00) ? 2'b01 : (m_mode == 2'b01) ? 2'b10 : 2'b00;

    @(posedge clock);
    @(negedge clock);
    in_valid = 0;
    out_ready = stray_ready;
    chk({tag, "_ph1_pol"}, alu_clock_pol, 1);
    chk({tag, "_ph1_ready"}, in_ready, 0);
    chk({tag, "_ph1_sel"}, alu_add_b_sel, exp_sel);
    chk({tag, "_alu_a"}, alu_a, a);
    chk({tag, "_mul_a_sel"}, alu_mul_a_sel, 0);

    @(negedge clock);
    chk({tag, "_ph2_pol"}, alu_clock_pol, 0);
    chk({tag, "_ph2_ready"}, in_ready, 0);
    chk({tag, "_ph2_valid"}, out_valid, 0);
    chk({tag, "_ph2_sel"}, alu_add_b_sel, exp_sel);
    if (abort) begin
      reset = 1;
      @(negedge clock);
      reset = 0;
      out_ready = 0;
      chk({tag, "_rst_ready"}, in_ready, 1);
      chk({tag, "_rst_valid"}, out_valid, 0);
      chk({tag, "_rst_acc1"}, alu_acc1, 0);
      chk({tag, "_rst_acc2"}, alu_acc2, 0);
      chk({tag, "_rst_pol"}, alu_clock_pol, 0);
      chk({tag, "_rst_sel"}, alu_add_b_sel, 2'b01);
      m1 = 0; m2 = 0; m_open = 0;
      fin = 0;
      return;
    end

    @(negedge clock);
    out_ready = 0;
    chk({tag, "_t3_pol"}, alu_clock_pol, 0);
    if (fin) begin
      chk({tag, "_out_valid"}, out_valid, 1);
      chk({tag, "_out_ready_low"}, in_ready, 0);
      chk({tag, "_r1"}, out_r1, m1[7:0]);
      chk({tag, "_r2"}, out_r2, m2[7:0]);
      m_open = 0;
    end else begin
      chk({tag, "_mac_ready"}, in_ready, 1);
      chk({tag, "_mac_valid"}, out_valid, 0);
      chk({tag, "_mac_acc1"}, alu_acc1, m1[7:0]);
      chk({tag, "_mac_acc2"}, alu_acc2, m2[7:0]);
      m_open = 1;
    end
  endtask

  task automatic consume(input int hold, input bit hold_in_valid, input string tag);
    out_ready = 0;
    if (hold_in_valid) begin
      in_valid = 1;
      in_a = 8'($urandom); in_b = 8'($urandom); in_c = 8'($urandom); in_d = 8'($urandom);
      in_mode = 2'($urandom); in_last = 1'($urandom);
    end
    repeat (hold) begin
      @(negedge clock);
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_ready"}, in_ready, 0);
      chk({tag, "_hold_r1"}, out_r1, m1[7:0]);
      chk({tag, "_hold_r2"}, out_r2, m2[7:0]);
    end
    out_ready = 1;
    @(negedge clock);
    out_ready = 0;
    in_valid = 0;
    chk({tag, "_done_valid"}, out_valid, 0);
    chk({tag, "_done_ready"}, in_ready, 1);
    chk({tag, "_done_acc1"}, alu_acc1, 0);
    chk({tag, "_done_acc2"}, alu_acc2, 0);
    m1 = 0; m2 = 0;
  endtask

  initial begin
    bit fin;
    logic [1:0] rm;
    logic rl;
    reset = 1; in_valid = 0; out_ready = 0;
    in_a = 0; in_b = 0; in_c = 0; in_d = 0; in_mode = 0; in_last = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_r1", out_r1, 0);
    chk("rst_r2", out_r2, 0);
    chk("rst_acc1", alu_acc1, 0);
    chk("rst_acc2", alu_acc2, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_d", alu_d, 0);
    chk("rst_sel", alu_add_b_sel, 2'b01);
    chk("rst_pol", alu_clock_pol, 0);

    // Directed: MUL
    term(8'd3, -8'sd2, 8'd5, 8'd7, 2'b00, 0, 0, 0, "mul", fin);
    chk("mul_r1_const", out_r1, 8'd15);
    chk("mul_r2_const", out_r2, 8'hF2);
    consume(0, 0, "mul");

    // Directed: ADD
    term(8'd3, 8'd2, 8'd5, 8'd4, 2'b01, 0, 0, 1, "add", fin);
    chk("add_r1_const", out_r1, 8'd23);
    chk("add_r2_const", out_r2, 8'd23);
    consume(0, 1, "add");

    // Directed: MAC group, second term carries a stray MUL mode
    term(8'd1, 8'd2, 8'd3, 8'd4, 2'b10, 0, 0, 1, "mac1", fin);
    term(8'd5, 8'd6, 8'd7, 8'd8, 2'b00, 0, 0, 0, "mac2", fin);
    term(-8'sd1, 8'd1, 8'd1, -8'sd1, 2'b10, 1, 0, 0, "mac3", fin);
    chk("mac_r1_const", out_r1, 8'd37);
    chk("mac_r2_const", out_r2, 8'd55);
    consume(1, 0, "mac");

    // Directed: wrap
    term(8'd16, 8'd0, 8'd16, 8'd0, 2'b00, 0, 0, 0, "wrap1", fin);
    chk("wrap1_r1_const", out_r1, 8'd0);
    consume(0, 0, "wrap1");
    term(8'd100, 8'd0, 8'd2, 8'd0, 2'b00, 0, 0, 0, "wrap2", fin);
    chk("wrap2_r1_const", out_r1, 8'hC8);
    consume(0, 0, "wrap2");
    term(8'd127, 8'd0, 8'd1, 8'd0, 2'b10, 0, 0, 0, "wrap3a", fin);
    term(8'd1, 8'd0, 8'd1, 8'd0, 2'b10, 1, 0, 0, "wrap3b", fin);
    chk("wrap3_r1_const", out_r1, 8'h80);
    consume(0, 0, "wrap3");

    // Directed: single-term MAC behaves as MUL
    term(8'd9, 8'd3, 8'd2, 8'd5, 2'b10, 1, 0, 0, "mac_single", fin);
    chk("mac_single_r1", out_r1, 8'd18);
    consume(0, 0, "mac_single");

    // Directed: backpressure with in_valid held through OUT
    term(8'd7, 8'd1, 8'd6, 8'd1, 2'b00, 0, 0, 0, "bp", fin);
    consume(5, 1, "bp");
    term(8'd2, 8'd0, 8'd3, 8'd0, 2'b00, 0, 0, 0, "bp_next", fin);
    chk("bp_next_r1_const", out_r1, 8'd6);
    consume(0, 0, "bp_next");

    // Directed: reset during PH2 of a MAC group
    term(8'd10, 8'd10, 8'd10, 8'd10, 2'b10, 0, 0, 0, "rst_mac1", fin);
    term(8'd3, 8'd3, 8'd3, 8'd3, 2'b10, 0, 1, 0, "rst_mac2", fin);
    term(8'd4, 8'd0, 8'd4, 8'd0, 2'b00, 0, 0, 0, "rst_after", fin);
    chk("rst_after_r1_const", out_r1, 8'd16);
    consume(0, 0, "rst_after");

    // Random commands
    for (int i = 0; i < 40; i++) begin
      rm = 2'($urandom_range(0, 3));
      rl = ($urandom_range(0, 2) == 0);
      term(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), rm, rl, 0,
           1'($urandom), "rnd", fin);
      if (fin) consume($urandom_range(0, 3), 1'($urandom), "rnd");
    end
    if (m_open) begin
      term(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2'b10, 1, 0, 0, "rnd_close", fin);
      consume(0, 0, "rnd_close");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
